// File: rtl/seq_multiplier_32bit_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package seq_multiplier_32bit_pkg;

  // Only 32 is supported: the datapath adder is fixed at 32 bits.
  localparam int unsigned WIDTH     = 32;
  // Iteration counter width; 2**CNT_W must exceed WIDTH.
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned ITER_LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit ripple/carry adder with carry-in and carry-out.
module adder_32bit (
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, input1} + {1'b0, input2} + {32'b0, cin};

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the multiplier: IDLE/RUN/DONE FSM plus the iteration counter.
module mult_ctrl
  import seq_multiplier_32bit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic shift_en,
  output logic busy,
  output logic done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_iter;

  assign last_iter = (count_q == CNT_W'(ITER_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_iter) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:  load = start;
      StRun: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      // Start is also accepted here so back-to-back operations lose no cycle.
      StDone: begin
        done = 1'b1;
        load = start;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (shift_en) begin
      count_d = count_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Unsigned 32x32 sequential multiplier: one shared adder, one iteration per cycle.
module seq_multiplier_32bit
  import seq_multiplier_32bit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               load, shift_en;
  logic [WIDTH-1:0]   add_b, add_sum;
  logic               add_cout;

  mult_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load     (load),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  assign add_b = p_q[0] ? mcand_q : '0;

  adder_32bit u_adder (
    .input1 (p_q[2*WIDTH-1:WIDTH]),
    .input2 (add_b),
    .cin    (1'b0),
    .sum    (add_sum),
    .cout   (add_cout)
  );

  // Upper half accumulates partial sums; the multiplier drains out of the lower half.
  always_comb begin
    mcand_d = mcand_q;
    p_d     = p_q;
    if (load) begin
      mcand_d = multiplicand;
      p_d     = {{WIDTH{1'b0}}, multiplier};
    end else if (shift_en) begin
      p_d = {add_cout, add_sum, p_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      p_q     <= '0;
    end else begin
      mcand_q <= mcand_d;
      p_q     <= p_d;
    end
  end

  assign product = p_q;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Scoreboard bench: stimulus queues expected products, a monitor checks each done pulse.
module tb_seq_multiplier_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];

  int          run_len   = 0;
  bit          prev_done = 1'b0;
  logic [63:0] last_prod = '0;

  seq_multiplier_32bit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic flag_fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          flag_fail("spurious_done", "done seen with nothing outstanding");
        end else begin
          e = exp_q.pop_front();
          check64("product", product, e);
          check64("busy_cycles", 64'(run_len), 64'd32);
          check64("busy_in_done", {63'b0, busy}, 64'd0);
        end
        if (prev_done) flag_fail("done_width", "done high for two cycles");
        last_prod = product;
      end else if (prev_done && !busy) begin
        check64("product_hold", product, last_prod);
      end
    end
    run_len   = busy ? run_len + 1 : 0;
    prev_done = done;
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_all();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check64("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check64("rst_busy", {63'b0, busy}, 64'd0);
    check64("rst_done", {63'b0, done}, 64'd0);
    check64("rst_product", product, 64'd0);
    reset = 1'b0;

    issue(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_all();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_all();
    issue(32'd0, 32'h1234_5678, 64'd0);
    wait_all();
    issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    wait_all();
    issue(32'd12345, 32'd6789, 64'd83810205);
    wait_all();

    // Start during RUN must be ignored.
    issue(32'd3, 32'd5, 64'd15);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_all();

    // Abort mid-run: no done pulse, everything cleared.
    issue(32'd3, 32'd5, 64'd15);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check64("abort_busy", {63'b0, busy}, 64'd0);
    check64("abort_done", {63'b0, done}, 64'd0);
    check64("abort_product", product, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd6, 32'd9, 64'd54);
    wait_all();

    // Back-to-back: start held in the DONE cycle.
    issue(32'd3, 32'd5, 64'd15);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      flag_fail("b2b_wait", "no done within bound");
    end else begin
      start = 1'b1;
      a     = 32'd10;
      b     = 32'd10;
      exp_q.push_back(64'd100);
      @(negedge clk);
      start = 1'b0;
    end
    wait_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
